irq_pending_4: RTL and testbench

Four-channel interrupt request capture stage feeding the 4-to-2 priority encoder. Synchronises four asynchronous request lines, detects rising edges, and holds a sticky pending flag per channel until the consumer acknowledges the serviced index. `pend` drives the encoder's `d[3:0]` directly. Per-channel masking, missed-event counting and acknowledge-error reporting support the service loop built around the encoder.

---
 rtl/irq_pkg.sv | 12 +
 rtl/sync_ff.sv | 21 ++
 rtl/irq_pending_4.sv | 95 +++++++++
 tb/tb_irq_pending_4.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt capture stage and the priority encoder.
package irq_pkg;

    localparam int NUM_CH = 4;

    // Channel index as produced by the 4-to-2 encoder.
    typedef logic [1:0] ch_idx_t;

    // All channels unmasked out of reset.
    localparam logic [NUM_CH-1:0] MASK_RST = '0;

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchroniser of configurable depth for one asynchronous request line.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; bit 0 is the metastable stage.
    always_ff @(posedge clk) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_pending_4.sv
// Four-channel interrupt capture: synchronise, rising-edge detect, sticky pending
// with acknowledge, per-channel mask on the output, and saturating miss counters.
module irq_pending_4
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       irq_in,
    input  logic                    mask_we,
    input  logic [NUM_CH-1:0]       mask_wdata,
    input  logic                    ack,
    input  ch_idx_t                 ack_idx,
    input  logic                    cnt_clr,
    output logic [NUM_CH-1:0]       pend,
    output logic                    pend_any,
    output logic [NUM_CH-1:0]       mask,
    output logic [NUM_CH*CNT_W-1:0] missed_cnt,
    output logic                    ack_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0]            sync;
    logic [NUM_CH-1:0]            prev;
    logic [NUM_CH-1:0]            edge_det;
    logic [NUM_CH-1:0]            ack_hit;
    logic [NUM_CH-1:0]            pending;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_sync
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_in[n]),
            .q    (sync[n])
        );
    end

    assign edge_det = sync & ~prev;
    assign ack_hit  = ack ? (NUM_CH'(1) << ack_idx) : '0;

    // Previous synchronised sample for edge detection; reset to 0 so a line
    // held high through reset release still yields one event.
    always_ff @(posedge clk) begin
        if (!rst_n) prev <= '0;
        else        prev <= sync;
    end

    // Sticky pending flags: a new edge wins over an ack of the same channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (edge_det[n])     pending[n] <= 1'b1;
                else if (ack_hit[n]) pending[n] <= 1'b0;
            end
        end
    end

    // Missed-event counters: an edge landing on an unserviced pending flag is a
    // miss; an edge coinciding with its own ack replaces the serviced event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (cnt_clr)
                    cnt[n] <= '0;
                else if (edge_det[n] && pending[n] && !ack_hit[n] && cnt[n] != CNT_MAX)
                    cnt[n] <= cnt[n] + 1'b1;
            end
        end
    end

    // Mask register; gates only the pend output, never the capture logic.
    always_ff @(posedge clk) begin
        if (!rst_n)       mask <= MASK_RST;
        else if (mask_we) mask <= mask_wdata;
    end

    // Ack of a channel with no raw pending event is flagged for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) ack_err <= 1'b0;
        else        ack_err <= ack && !pending[ack_idx];
    end

    assign pend       = pending & ~mask;
    assign pend_any   = |pend;
    assign missed_cnt = cnt;

endmodule

// File: tb/tb_irq_pending_4.sv
// Scoreboard bench for irq_pending_4: a cycle model pushes the expected
// post-edge outputs when inputs are driven; they are popped and compared
// after the edge. Directed constant checks cover the key scenarios.
module tb_irq_pending_4;

    localparam int SS = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      irq_in = '0;
    logic            mask_we = 1'b0;
    logic [3:0]      mask_wdata = '0;
    logic            ack = 1'b0;
    logic [1:0]      ack_idx = '0;
    logic            cnt_clr = 1'b0;
    logic [3:0]      pend;
    logic            pend_any;
    logic [3:0]      mask;
    logic [4*CW-1:0] missed_cnt;
    logic            ack_err;

    int n_chk = 0;
    int n_fail = 0;

    irq_pending_4 #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .ack       (ack),
        .ack_idx   (ack_idx),
        .cnt_clr   (cnt_clr),
        .pend      (pend),
        .pend_any  (pend_any),
        .mask      (mask),
        .missed_cnt(missed_cnt),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      pend;
        logic            any;
        logic [3:0]      mask;
        logic [4*CW-1:0] cnt;
        logic            err;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [3:0] m_sync [SS];
    logic [3:0] m_prev, m_pending, m_mask;
    int         m_cnt [4];
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int n);
        return int'(missed_cnt[n*CW +: CW]);
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic [3:0] edg;
        logic [3:0] old_pend;
        bit         ackn;
        if (!rst_n) begin
            for (int s = 0; s < SS; s++) m_sync[s] = '0;
            m_prev = '0; m_pending = '0; m_mask = '0; m_err = 1'b0;
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        end else begin
            edg = m_sync[SS-1] & ~m_prev;
            old_pend = m_pending;
            for (int n = 0; n < 4; n++) begin
                ackn = ack && (int'(ack_idx) == n);
                if (cnt_clr) m_cnt[n] = 0;
                else if (edg[n] && old_pend[n] && !ackn && m_cnt[n] < CMAX) m_cnt[n]++;
                if (edg[n]) m_pending[n] = 1'b1;
                else if (ackn) m_pending[n] = 1'b0;
            end
            m_err = ack && !old_pend[ack_idx];
            if (mask_we) m_mask = mask_wdata;
            m_prev = m_sync[SS-1];
            for (int s = SS-1; s > 0; s--) m_sync[s] = m_sync[s-1];
            m_sync[0] = irq_in;
        end
    endtask

    // One clock: push model expectation, clock, then pop and compare.
    task automatic tick();
        exp_t e;
        logic [4*CW-1:0] c;
        model_step();
        for (int n = 0; n < 4; n++) c[n*CW +: CW] = CW'(m_cnt[n]);
        e.pend = m_pending & ~m_mask;
        e.any  = |(m_pending & ~m_mask);
        e.mask = m_mask;
        e.cnt  = c;
        e.err  = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_pend", 32'(pend), 32'(e.pend));
            chk("sb_pend_any", 32'(pend_any), 32'(e.any));
            chk("sb_mask", 32'(mask), 32'(e.mask));
            chk("sb_missed_cnt", 32'(missed_cnt), 32'(e.cnt));
            chk("sb_ack_err", 32'(ack_err), 32'(e.err));
        end
    endtask

    task automatic pulse(input int n, input int hi, input int lo);
        irq_in[n] = 1'b1;
        repeat (hi) tick();
        irq_in[n] = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        for (int s = 0; s < SS; s++) m_sync[s] = '0;
        m_prev = '0; m_pending = '0; m_mask = '0; m_err = 1'b0;
        for (int n = 0; n < 4; n++) m_cnt[n] = 0;

        // Reset state
        ack = 1'b1; ack_idx = 2'd1;   // ack during reset must be ignored
        repeat (2) tick();
        ack = 1'b0;
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_err", 32'(ack_err), 32'h0);
        chk("rst_cnt", 32'(missed_cnt), 32'h0);
        rst_n = 1'b1;

        // Ch2 latency: first sampling edge is the next one; pend after the third
        irq_in[2] = 1'b1;
        tick(); chk("lat_e1", 32'(pend), 32'h0);
        tick(); chk("lat_e2", 32'(pend), 32'h0);
        tick(); chk("lat_e3", 32'(pend), 32'h4);
        chk("lat_any", 32'(pend_any), 32'h1);
        irq_in[2] = 1'b0;
        repeat (2) tick();

        // Ack ch2
        ack = 1'b1; ack_idx = 2'd2;
        tick();
        ack = 1'b0;
        chk("ack2_pend", 32'(pend), 32'h0);
        chk("ack2_err", 32'(ack_err), 32'h0);
        chk("ack2_cnt", 32'(cnt_of(2)), 32'd0);

        // Ch1: one event plus 20 unserviced edges saturates the counter
        for (int i = 0; i < 21; i++) pulse(1, 2, 2);
        repeat (3) tick();
        chk("sat_cnt1", 32'(cnt_of(1)), 32'd15);
        chk("sat_pend", 32'(pend), 32'h2);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt1", 32'(cnt_of(1)), 32'd0);
        ack = 1'b1; ack_idx = 2'd1;
        tick();
        ack = 1'b0;

        // Mask ch3, event held while masked, then exposed on unmask
        mask_we = 1'b1; mask_wdata = 4'b1000;
        tick();
        mask_we = 1'b0;
        chk("mask_rd", 32'(mask), 32'h8);
        pulse(3, 2, 4);
        chk("mask_pend", 32'(pend), 32'h0);
        chk("mask_any", 32'(pend_any), 32'h0);
        mask_we = 1'b1; mask_wdata = 4'b0000;
        tick();
        mask_we = 1'b0;
        chk("unmask_pend", 32'(pend), 32'h8);

        // Errored ack of idle ch0
        ack = 1'b1; ack_idx = 2'd0;
        tick();
        ack = 1'b0;
        chk("err_hi", 32'(ack_err), 32'h1);
        chk("err_pend", 32'(pend), 32'h8);
        tick();
        chk("err_lo", 32'(ack_err), 32'h0);

        // New ch3 edge in the same cycle as ack of ch3
        irq_in[3] = 1'b1;
        repeat (SS) tick();
        ack = 1'b1; ack_idx = 2'd3;
        tick();
        ack = 1'b0;
        irq_in[3] = 1'b0;
        chk("same_pend3", 32'(pend[3]), 32'h1);
        chk("same_cnt3", 32'(cnt_of(3)), 32'd0);
        repeat (2) tick();

        // Build ch0 and ch3 pending with nonzero counters, then reset
        pulse(0, 2, 2);
        pulse(0, 2, 2);
        pulse(3, 2, 4);
        chk("pre_cnt0", 32'(cnt_of(0)), 32'd1);
        chk("pre_cnt3", 32'(cnt_of(3)), 32'd1);
        chk("pre_pend", 32'(pend), 32'h9);
        rst_n = 1'b0;
        ack = 1'b1; ack_idx = 2'd3;
        irq_in[0] = 1'b1;              // held high through reset release
        tick();
        ack = 1'b0;
        chk("rst2_pend", 32'(pend), 32'h0);
        chk("rst2_any", 32'(pend_any), 32'h0);
        chk("rst2_cnt", 32'(missed_cnt), 32'h0);
        chk("rst2_err", 32'(ack_err), 32'h0);
        chk("rst2_mask", 32'(mask), 32'h0);
        rst_n = 1'b1;

        // Held-high line yields exactly one event
        repeat (SS + 2) tick();
        chk("held_pend", 32'(pend), 32'h1);
        ack = 1'b1; ack_idx = 2'd0;
        tick();
        ack = 1'b0;
        repeat (4) tick();
        chk("held_once", 32'(pend), 32'h0);
        chk("held_cnt0", 32'(cnt_of(0)), 32'd0);
        irq_in[0] = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
